div_gen: RTL
============

DIV_GEN -- requirements
Module: div_gen

Interface
REQ-001 Parameter W, default 32, operand and result width; W >= 2.
REQ-002 Parameter CBIT, default 6, iteration-counter width; 2**CBIT > W.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  request a division; accepted only while ready=1.
REQ-006 sgn  input  1  signed-mode request, sampled with start.
REQ-007 dvnd  input  W  dividend, sampled with start.
REQ-008 dvsr  input  W  divisor, sampled with start.
REQ-009 quo  output  W  quotient register.
REQ-010 rmd  output  W  remainder register.
REQ-011 err  output  1  error flag for the last result (divide-by-zero or signed overflow).
REQ-012 ready  output  1  high while idle and able to accept start.
REQ-013 done_tick  output  1  one-cycle pulse marking a completed result.

Function
REQ-014 FSM states SHALL be idle, op, last and done; the cycle-level rules follow.
- idle: ready=1; start=1 -> op, latching dvnd, dvsr and sgn; otherwise stay idle.
- op: one restoring shift-subtract quotient bit per cycle.
- last: final bit, sign correction and result write.
- done: done_tick=1 for one cycle -> idle.
REQ-015 Latency SHALL be fixed: start sampled at edge E0; op occupies W-1 cycles; last occupies 1 cycle; done_tick SHALL be high in exactly the cycle after edge E(W+1), for every operand value.
REQ-016 ready SHALL be 0 from the cycle after E0 through the done cycle inclusive; it SHALL return to 1 in the cycle after done.
REQ-017 start while ready=0 SHALL be ignored: no effect on state, latched operands or outputs.
REQ-018 start high in the done cycle SHALL be ignored; back-to-back throughput SHALL be one division per W+3 cycles.
REQ-019 Unsigned mode: quo = floor(dvnd/dvsr) and rmd = dvnd mod dvsr, both W bits.
REQ-020 Signed mode: operands are two's complement; the divider works on magnitudes; quo SHALL truncate toward zero; rmd SHALL take the sign of dvnd; a zero remainder SHALL be 0.
REQ-021 Divide-by-zero (dvsr=0), either mode: quo = all ones, rmd = dvnd, err = 1; latency unchanged.
REQ-022 Signed overflow (dvnd = most-negative and dvsr = -1): quo = most-negative, rmd = 0, err = 1.
REQ-023 err SHALL be 0 for every other completed operation.
REQ-024 quo, rmd and err SHALL be written only at the last->done transition; they SHALL then hold until the next result is written.
REQ-025 Outputs SHALL be unchanged from the previous result while a new operation runs.

Reset
REQ-026 reset=1 at a rising edge SHALL force idle; quo=0, rmd=0, err=0, done_tick=0, and ready=1 in the following cycle.
REQ-027 reset asserted in op or last SHALL abort the operation; no done_tick SHALL follow.
REQ-028 reset SHALL take priority over a simultaneous start.

Configuration
REQ-029 Macro DIV_GEN_SIGNED_EN defined: the sgn input selects signed mode per REQ-020 and REQ-022.
REQ-030 Macro DIV_GEN_SIGNED_EN undefined:
- sgn is ignored and every operation is unsigned.
- The signed overflow case never sets err.
- The sign-correction logic is not synthesised.
- The port list is unchanged.

Verification (W=8, CBIT=4, DIV_GEN_SIGNED_EN defined unless stated)
REQ-031 Unsigned divide: dvnd=100, dvsr=7, sgn=0, start pulse -> done_tick exactly 9 cycles after the start edge; quo=14, rmd=2, err=0; ready=1 one cycle later.
REQ-032 Signed divide: dvnd=0x9C (-100), dvsr=7, sgn=1 -> quo=0xF2 (-14), rmd=0xFE (-2), err=0.
REQ-033 Error cases:
- dvnd=5, dvsr=0 -> quo=0xFF, rmd=5, err=1.
- dvnd=0x80, dvsr=0xFF, sgn=1 -> quo=0x80, rmd=0, err=1.
- With DIV_GEN_SIGNED_EN undefined, the same 0x80/0xFF operation with sgn=1 -> quo=0, rmd=0x80, err=0.
REQ-034 Busy-start test: a start with different operands during op is ignored; the first result is delivered unchanged.
REQ-035 Reset-abort test: reset pulsed at cycle 4 of an operation -> no done_tick; quo=0, rmd=0; ready=1 the next cycle.
REQ-036 Back-to-back test: start held high continuously -> one done_tick every 11 cycles with correct results.

Source files
------------

// File: rtl/div_gen_if.sv
// Request/result bundle for div_gen: operands and start in, quotient/remainder/flags out.
// The master drives start and operands; the slave (divider) returns ready, done_tick and the result.
interface div_gen_if #(
    parameter int W = 32
);
    logic         start;
    logic         sgn;
    logic [W-1:0] dvnd;
    logic [W-1:0] dvsr;
    logic [W-1:0] quo;
    logic [W-1:0] rmd;
    logic         err;
    logic         ready;
    logic         done_tick;

    modport master (
        output start, sgn, dvnd, dvsr,
        input  quo, rmd, err, ready, done_tick
    );

    modport slave (
        input  start, sgn, dvnd, dvsr,
        output quo, rmd, err, ready, done_tick
    );
endinterface

// File: rtl/div_gen.sv
// Restoring sequential divider, one quotient bit per cycle; done_tick W+1 cycles after start, one op at a time.
// Starts are only taken while ready=1; DIV_GEN_SIGNED_EN enables signed mode via sgn.
module div_gen #(
    parameter int W    = 32,
    parameter int CBIT = 6
) (
    input  logic     clk,
    input  logic     reset,
    div_gen_if.slave bus
);

    localparam logic [W-1:0]    MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [CBIT-1:0] LAST_CNT = CBIT'(W - 2);

    typedef enum logic [1:0] {
        IDLE,
        OP,
        LAST,
        DONE
    } state_t;

    state_t          r_state;
    logic [CBIT-1:0] r_cnt;
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_dvsr;
    logic [W-1:0]    r_dvnd_raw;
    logic            r_dz;
    logic            r_ovf;
    logic [W-1:0]    r_quo;
    logic [W-1:0]    r_rmd;
    logic            r_err;
    logic            r_ready;
    logic            r_done_tick;

    logic            w_accept;
    logic [W:0]      w_trial;
    logic [W:0]      w_diff;
    logic            w_ge;
    logic [W-1:0]    w_rem_nxt;
    logic [W-1:0]    w_acc_nxt;
    logic [W-1:0]    w_mag_n;
    logic [W-1:0]    w_mag_d;
    logic            w_ovf_in;
    logic [W-1:0]    w_q_sign;
    logic [W-1:0]    w_r_sign;
    logic [W-1:0]    w_quo_fin;
    logic [W-1:0]    w_rmd_fin;

    assign w_accept = bus.start & r_ready & (r_state == IDLE);

    // Partial remainder stays below the divisor, so a borrow in the top bit means "does not fit".
    assign w_trial   = {r_rem, r_acc[W-1]};
    assign w_diff    = w_trial - {1'b0, r_dvsr};
    assign w_ge      = ~w_diff[W];
    assign w_rem_nxt = w_ge ? w_diff[W-1:0] : w_trial[W-1:0];
    assign w_acc_nxt = {r_acc[W-2:0], w_ge};

`ifdef DIV_GEN_SIGNED_EN
    logic w_neg_n;
    logic w_neg_d;
    logic r_neg_q;
    logic r_neg_r;

    assign w_neg_n  = bus.sgn & bus.dvnd[W-1];
    assign w_neg_d  = bus.sgn & bus.dvsr[W-1];
    assign w_mag_n  = w_neg_n ? (W'(0) - bus.dvnd) : bus.dvnd;
    assign w_mag_d  = w_neg_d ? (W'(0) - bus.dvsr) : bus.dvsr;
    assign w_ovf_in = bus.sgn & (bus.dvnd == MOST_NEG) & (bus.dvsr == '1);
    assign w_q_sign = r_neg_q ? (W'(0) - w_acc_nxt) : w_acc_nxt;
    assign w_r_sign = r_neg_r ? (W'(0) - w_rem_nxt) : w_rem_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_neg_n ^ w_neg_d;
            r_neg_r <= w_neg_n;
        end
    end
`else
    assign w_mag_n  = bus.dvnd;
    assign w_mag_d  = bus.dvsr;
    assign w_ovf_in = 1'b0;
    assign w_q_sign = w_acc_nxt;
    assign w_r_sign = w_rem_nxt;
`endif

    always_comb begin
        w_quo_fin = w_q_sign;
        w_rmd_fin = w_r_sign;
        if (r_dz) begin
            w_quo_fin = '1;
            w_rmd_fin = r_dvnd_raw;
        end else if (r_ovf) begin
            w_quo_fin = MOST_NEG;
            w_rmd_fin = '0;
        end
    end

    // done_tick and ready trail the state by one cycle, giving the W+3 issue period.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_acc       <= '0;
            r_dvsr      <= '0;
            r_dvnd_raw  <= '0;
            r_dz        <= 1'b0;
            r_ovf       <= 1'b0;
            r_quo       <= '0;
            r_rmd       <= '0;
            r_err       <= 1'b0;
            r_ready     <= 1'b1;
            r_done_tick <= 1'b0;
        end else begin
            r_done_tick <= (r_state == DONE);
            r_ready     <= (r_state == IDLE) && !w_accept;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        r_acc      <= w_mag_n;
                        r_dvsr     <= w_mag_d;
                        r_dvnd_raw <= bus.dvnd;
                        r_dz       <= (bus.dvsr == '0);
                        r_ovf      <= w_ovf_in;
                        r_state    <= OP;
                    end
                end
                OP: begin
                    r_rem <= w_rem_nxt;
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CBIT'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_state <= LAST;
                    end
                end
                LAST: begin
                    r_quo   <= w_quo_fin;
                    r_rmd   <= w_rmd_fin;
                    r_err   <= r_dz | r_ovf;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.quo       = r_quo;
    assign bus.rmd       = r_rmd;
    assign bus.err       = r_err;
    assign bus.ready     = r_ready;
    assign bus.done_tick = r_done_tick;

endmodule
